// File: rtl/serial_enable_sequencer.sv
// serial_enable_sequencer: drives a per-bit-enabled capture register.
// Accepts a WIDTH-bit word over valid/ready, then shifts it out LSB
// first on d_out_o with a one-hot en_o pulse per bit slot.
// Ports:
//   clk_i       sole clock, posedge
//   rst_n_i     synchronous active-low reset
//   in_data_i   word to write, sampled on handshake
//   in_valid_i  in_data_i valid
//   in_ready_o  sequencer can accept a word
//   en_o        one-hot per-bit enable (en_o[k] -> downstream En(k+1))
//   d_out_o     serial data (0 whenever en_o is 0)
//   busy_o      sequence in progress
//   done_o      one-cycle pulse in the first idle cycle after a sequence
// Optional feature (macro SEQ_SKIP_UNCHANGED_EN): keep a shadow of the
// downstream register and suppress enables for bits that would not change.
module serial_enable_sequencer #(
   parameter int WIDTH = 5
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] en_o,
   output logic             d_out_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] word_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] en_q;
   logic             d_q;
   logic             rdy_q;
   logic             busy_q;
   logic             done_q;

   // Slot that will be presented in the cycle after the coming edge.
   logic [WIDTH-1:0] slot_word;
   logic [IW-1:0]    slot_idx;
   logic             slot_bit;
   logic             slot_on;
   logic [WIDTH-1:0] slot_en;
   logic             load;
   logic             last;

   always_comb begin
      slot_word = word_q;
      slot_idx  = idx_q + IW'(1);
      if (state_q == IDLE) begin
         slot_word = in_data_i;
         slot_idx  = '0;
      end
      slot_bit = slot_word[slot_idx];
      slot_en  = '0;
      if (slot_on) begin
         slot_en = WIDTH'(1) << slot_idx;
      end
      last = (state_q == SHIFT) && (idx_q == IW'(WIDTH - 1));
      load = ((state_q == IDLE) && in_valid_i && rdy_q)
           || ((state_q == SHIFT) && !last);
   end

`ifdef SEQ_SKIP_UNCHANGED_EN
   logic [WIDTH-1:0] shadow_q;
   logic             shadow_vld_q;

   assign slot_on = !shadow_vld_q || (slot_bit != shadow_q[slot_idx]);

   // Shadow only becomes trustworthy once a full sequence has landed;
   // an aborted sequence leaves it invalid so the next word writes all bits.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
      end else begin
         if (load && slot_on) begin
            shadow_q[slot_idx] <= slot_bit;
         end
         if (last) begin
            shadow_vld_q <= 1'b1;
         end
      end
   end
`else
   assign slot_on = 1'b1;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         en_q    <= '0;
         d_q     <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (load) begin
                  word_q  <= in_data_i;
                  idx_q   <= '0;
                  en_q    <= slot_en;
                  d_q     <= slot_on & slot_bit;
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  rdy_q <= 1'b1;
               end
            end
            SHIFT: begin
               if (last) begin
                  en_q    <= '0;
                  d_q     <= 1'b0;
                  rdy_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  idx_q <= slot_idx;
                  en_q  <= slot_en;
                  d_q   <= slot_on & slot_bit;
               end
            end
         endcase
      end
   end

   assign in_ready_o = rdy_q;
   assign en_o       = en_q;
   assign d_out_o    = d_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_serial_enable_sequencer.sv
// tb_serial_enable_sequencer: random and directed stimulus checked
// against a slot-offset reference model and a downstream register model.
module tb_serial_enable_sequencer;

   localparam int W = 5;
`ifdef SEQ_SKIP_UNCHANGED_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready_o;
   logic [W-1:0] en_o;
   logic         d_out_o;
   logic         busy_o;
   logic         done_o;

   int checks = 0;
   int failures = 0;

   serial_enable_sequencer #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready_o),
      .en_o       (en_o),
      .d_out_o    (d_out_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   // Downstream per-bit-enabled register (not reset by the sequencer).
   logic [W-1:0] ds = '0;
   always @(posedge clk) begin
      for (int k = 0; k < W; k++) begin
         if (en_o[k]) ds[k] <= d_out_o;
      end
   end

   // Reference model: ofs = cycles since accept (0 = none),
   // 1..W are bit slots, W+1 is the DONE cycle.
   int           ofs = 0;
   logic [W-1:0] mw = '0;
   logic [W-1:0] mmask = '1;
   logic [W-1:0] shadow = '0;
   logic         svld = 1'b0;
   logic         after_rst = 1'b1;
   logic         macc = 1'b0;
   logic [W-1:0] ds_m = '0;
   int           cyc = 0;
   int           pulses = 0;

   function automatic logic ready_now();
      return !after_rst && (ofs == 0 || ofs == W + 1);
   endfunction

   // {ready, busy, done, en, d}
   function automatic logic [8:0] exp_out();
      logic [W-1:0] e;
      logic         dd;
      e = '0;
      if (ofs >= 1 && ofs <= W) e = (W'(1) << (ofs - 1)) & mmask;
      dd = |(e & mw);
      return {ready_now(), (ofs >= 1 && ofs <= W), (ofs == W + 1), e, dd};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rn, input logic v, input logic [W-1:0] dat);
      logic [8:0]   e;
      logic [W-1:0] ec;
      logic         rdy;
      e   = exp_out();
      ec  = e[W:1];
      ds_m = (ds_m & ~ec) | (e[0] ? ec : '0);
      rdy  = ready_now();
      macc = 1'b0;
      if (!rn) begin
         ofs = 0;
         after_rst = 1'b1;
         svld = 1'b0;
      end else begin
         after_rst = 1'b0;
         if (v && rdy) begin
            macc  = 1'b1;
            ofs   = 1;
            mw    = dat;
            mmask = (SKIP && svld) ? (dat ^ shadow) : '1;
         end else if (ofs >= 1 && ofs < W) begin
            ofs++;
         end else if (ofs == W) begin
            ofs = W + 1;
            if (SKIP) begin
               svld = 1'b1;
               shadow = mw;
            end
         end else begin
            ofs = 0;
         end
      end
   endtask

   task automatic cycle(input logic rn, input logic v, input logic [W-1:0] dat);
      logic [8:0] got;
      rst_n = rn;
      in_valid = v;
      in_data = dat;
      step(rn, v, dat);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      got = {in_ready_o, busy_o, done_o, en_o, d_out_o};
      chk("outs", 32'(got), 32'(exp_out()));
      chk("ds", 32'(ds), 32'(ds_m));
      pulses += $countones(en_o);
   endtask

   task automatic send(input logic [W-1:0] w);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, w);
         if (macc) return;
      end
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, W'($urandom));
   endtask

   int a1;
   int a2;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      chk("rst_ready", 32'(in_ready_o), 32'd0);
      cycle(1'b1, 1'b0, '0);
      chk("ready_rise", 32'(in_ready_o), 32'd1);

      send(5'b10110);
      drain(5);
      chk("done_t6", 32'(done_o), 32'd1);
      chk("ds_10110", 32'(ds), 32'h16);

      send(5'b00001);
      a1 = cyc;
      send(5'b11110);
      a2 = cyc;
      chk("b2b_gap", 32'(a2 - a1), 32'd6);
      drain(6);
      chk("ds_11110", 32'(ds), 32'h1e);

      send(5'b01011);
      cycle(1'b1, 1'b1, 5'b10100);
      chk("busy_ready", 32'(in_ready_o), 32'd0);
      cycle(1'b1, 1'b1, 5'b10100);
      drain(5);
      chk("ds_01011", 32'(ds), 32'h0b);

      send(5'b00000);
      drain(6);
      send(5'b11111);
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      chk("abort_en", 32'(en_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("ds_abort", 32'(ds), 32'h07);
      cycle(1'b1, 1'b0, '0);
      chk("abort_ready", 32'(in_ready_o), 32'd1);

      send(5'b10101);
      drain(6);
      pulses = 0;
      send(5'b10111);
      drain(5);
      chk("skip_done", 32'(done_o), 32'd1);
      chk("skip_pulses", 32'(pulses), SKIP ? 32'd1 : 32'd5);
      chk("ds_10111", 32'(ds), 32'h17);

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
               W'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
